// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Purpose:
//   Carries the fetch-stage branch prediction into decode and checks it
//   against the decode-stage branch outcome. On a mispredict it produces a
//   registered one-cycle redirect to the recovery PC and flushes the IF/ID
//   and ID/EX pipeline registers. Every resolved branch also produces a
//   one-cycle BTB/predictor update strobe. Saturating counters track the
//   number of resolved branches and the number of mispredicts.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   pred_taken_f        fetch-stage predictor select (taken & valid & hit)
//   pred_target_f       fetch-stage predicted target
//   stall_d             decode hold from the hazard unit
//   branch_d            decode instruction is a branch
//   branch_taken_d      actual branch outcome in decode
//   pc_d, pc_plus4_d    PC and PC+4 of the decode instruction
//   pc_branch_d         computed branch target in decode
//   redirect            next PC must be redirect_pc
//   redirect_pc         recovery PC
//   flush_fd, flush_de  clear IF/ID and ID/EX this edge
//   btb_wr_en           one-cycle BTB update strobe
//   btb_wr_pc           branch PC for the update
//   btb_wr_target       resolved target
//   btb_wr_taken        resolved outcome
//   br_cnt              resolved branches (saturating)
//   mispred_cnt         mispredicts (saturating)
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_taken_f,
    input  logic [31:0]      pred_target_f,
    input  logic             stall_d,
    input  logic             branch_d,
    input  logic             branch_taken_d,
    input  logic [31:0]      pc_d,
    input  logic [31:0]      pc_plus4_d,
    input  logic [31:0]      pc_branch_d,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             btb_wr_en,
    output logic [31:0]      btb_wr_pc,
    output logic [31:0]      btb_wr_target,
    output logic             btb_wr_taken,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef enum logic {
        NORMAL   = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    state_e            state_q, state_d;

    logic              pred_taken_q;
    logic [31:0]       pred_target_q;
    logic [31:0]       redirect_pc_q;
    logic              btb_wr_en_q;
    logic [31:0]       btb_wr_pc_q;
    logic [31:0]       btb_wr_target_q;
    logic              btb_wr_taken_q;
    logic [CNT_W-1:0]  br_cnt_q;
    logic [CNT_W-1:0]  mispred_cnt_q;

    logic              resolve;
    logic              mispredict;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Only branches seen in NORMAL are on the correct path; anything in
    // decode during REDIRECT is about to be flushed.
    assign resolve = branch_d && !stall_d && (state_q == NORMAL);

    // Taken-with-wrong-target counts as a mispredict just like a
    // direction error.
    assign mispredict = resolve &&
                        ((branch_taken_d != pred_taken_q) ||
                         (branch_taken_d && pred_taken_q &&
                          (pred_target_q != pc_branch_d)));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        redirect    = 1'b0;
        flush_fd    = 1'b0;
        flush_de    = 1'b0;
        redirect_pc = redirect_pc_q;
        unique case (state_q)
            NORMAL: begin
                if (mispredict) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                // Always exactly one cycle; a stall cannot extend it.
                redirect = 1'b1;
                flush_fd = 1'b1;
                flush_de = 1'b1;
                state_d  = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    // ---------------- Prediction tag (fetch -> decode) ----------------
    always_ff @(posedge clk) begin
        if (rst || flush_fd) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'h0;
        end else if (!stall_d) begin
            pred_taken_q  <= pred_taken_f;
            pred_target_q <= pred_target_f;
        end
    end

    // ---------------- Recovery PC ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc_q <= 32'h0;
        end else if (mispredict) begin
            redirect_pc_q <= branch_taken_d ? pc_branch_d : pc_plus4_d;
        end
    end

    // ---------------- BTB update and statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_wr_en_q     <= 1'b0;
            btb_wr_pc_q     <= 32'h0;
            btb_wr_target_q <= 32'h0;
            btb_wr_taken_q  <= 1'b0;
            br_cnt_q        <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            btb_wr_en_q <= resolve;
            if (resolve) begin
                btb_wr_pc_q     <= pc_d;
                btb_wr_target_q <= pc_branch_d;
                btb_wr_taken_q  <= branch_taken_d;
                br_cnt_q        <= sat_inc(br_cnt_q);
            end
            if (mispredict) begin
                mispred_cnt_q <= sat_inc(mispred_cnt_q);
            end
        end
    end

    assign btb_wr_en     = btb_wr_en_q;
    assign btb_wr_pc     = btb_wr_pc_q;
    assign btb_wr_target = btb_wr_target_q;
    assign btb_wr_taken  = btb_wr_taken_q;
    assign br_cnt        = br_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Pipeline-control block that sequences the BTB/2-bit branch predictor against decode-stage branch resolution in the 5-stage MIPS core.
- Carries each fetch-stage prediction alongside its instruction into decode and checks it when the branch resolves.
- On a mispredict, schedules a registered one-cycle redirect that selects the recovery PC and flushes the wrong-path IF/ID and ID/EX contents.
- Issues one BTB update pulse per resolved branch and keeps saturating branch and mispredict statistics counters.

Parameters:
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
pred_taken_f  input  1  predictor select for the instruction in fetch (taken & valid & tag hit)
pred_target_f  input  32  predicted target for the instruction in fetch
stall_d  input  1  hazard-unit stall of IF/ID (decode holds)
branch_d  input  1  decode instruction is a branch
branch_taken_d  input  1  actual branch outcome in decode
pc_d  input  32  PC of the decode instruction
pc_plus4_d  input  32  PC+4 of the decode instruction
pc_branch_d  input  32  computed branch target in decode
redirect  output  1  next PC must be redirect_pc
redirect_pc  output  32  recovery PC
flush_fd  output  1  clear IF/ID register this edge
flush_de  output  1  clear ID/EX register this edge
btb_wr_en  output  1  one-cycle BTB/counter update strobe
btb_wr_pc  output  32  branch PC for update
btb_wr_target  output  32  resolved target
btb_wr_taken  output  1  resolved outcome
br_cnt  output  CNT_W  resolved branches (saturating)
mispred_cnt  output  CNT_W  mispredicts (saturating)

Behaviour:
- Prediction tag register (pred_taken_q, pred_target_q) is the fetch-side prediction moved into decode.
  - Loads from the _f inputs on an edge with !stall_d and !flush_fd.
  - Cleared to 0 on flush_fd.
  - Held on stall_d.
- Resolve event: branch_d & !stall_d & state==NORMAL.
  - Branches in decode during REDIRECT are wrong-path and are ignored: no update, no count.
- Mispredict on a resolve event when any of the following holds:
  - branch_taken_d & !pred_taken_q (type T).
  - !branch_taken_d & pred_taken_q (type NT).
  - branch_taken_d & pred_taken_q & pred_target_q != pc_branch_d (type target).
- FSM states NORMAL and REDIRECT.
  - NORMAL -> REDIRECT at the edge ending a mispredicting resolve cycle.
  - REDIRECT -> NORMAL unconditionally after 1 cycle.
- On that edge, redirect_pc_q is latched:
  - pc_branch_d if taken.
  - pc_plus4_d if not taken.
- In REDIRECT (combinational from state):
  - redirect=1, redirect_pc=redirect_pc_q.
  - flush_fd=1, flush_de=1.
- In NORMAL: redirect=0, flush_fd=0, flush_de=0. redirect_pc holds its last value.
- Mispredict penalty is exactly 2 cycles: the branch resolves in decode at cycle N, redirect fires at N+1, and the correct path is fetched at N+2.
- stall_d during REDIRECT does not extend REDIRECT. The flush takes priority over the stall.
- BTB update is registered:
  - The edge after every resolve event drives btb_wr_en=1 for exactly 1 cycle.
  - btb_wr_pc=pc_d, btb_wr_target=pc_branch_d, btb_wr_taken=branch_taken_d, all captured at that event.
  - The update is issued for correct predictions too, so the predictor counter trains.
- Counters update on the same edge as the BTB update latch:
  - br_cnt+1 per resolve event.
  - mispred_cnt+1 per mispredict.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Back-to-back resolve events in NORMAL on consecutive cycles each produce their own btb_wr_en pulse; the pulses are contiguous.
- Reset values:
  - state=NORMAL, all outputs 0.
  - pred_taken_q=0, pred_target_q=0, redirect_pc_q=0.
  - Counters 0.
- Reset asserted in REDIRECT: the next edge returns to NORMAL with the flush, redirect and btb_wr_en outputs all 0. The pending redirect is discarded.

Test Plan:
- Reset check: assert rst 2 cycles -> redirect=flush_fd=flush_de=btb_wr_en=0, br_cnt=mispred_cnt=0.
- Correct taken prediction: pred_taken_f=1, pred_target_f=0x40 advances; next cycle branch_d=1, branch_taken_d=1, pc_branch_d=0x40, pc_d=0x10 -> no redirect; next cycle btb_wr_en=1, btb_wr_pc=0x10, btb_wr_target=0x40, btb_wr_taken=1; br_cnt=1, mispred_cnt=0.
- Not-taken mispredict: pred_taken_q=1, branch_taken_d=0, pc_plus4_d=0x24 -> following cycle redirect=1, redirect_pc=0x24, flush_fd=flush_de=1 for exactly 1 cycle; mispred_cnt=1.
- Wrong-target mispredict: pred_target_q=0x80, pc_branch_d=0x90, taken -> redirect_pc=0x90. A branch_d=1 in the REDIRECT cycle -> no btb_wr_en, br_cnt unchanged.
- Stall gating: branch_d=1 with stall_d=1 for 3 cycles, then stall_d=0 -> a single resolve, a single btb_wr_en pulse, pred_taken_q held throughout the stall.
- Saturation and reset mid-op: with CNT_W=2, drive 5 mispredicts -> mispred_cnt=3. Assert rst during REDIRECT -> next cycle redirect=0, state NORMAL.
